// File: rtl/key_cmd_scheduler_if.sv
// Command handshake between the key scheduler (master) and the Ethernet TX control (slave).
interface key_cmd_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_id;
    logic       tx_done;

    modport master (output cmd_valid, output cmd_id, input cmd_ready, input tx_done);
    modport slave  (input cmd_valid, input cmd_id, output cmd_ready, output tx_done);
endinterface

// File: rtl/key_cmd_scheduler.sv
// Latches debounced key presses and serialises them round-robin into TX commands,
// waiting for TX completion (with optional timeout) and enforcing an idle gap.
module key_cmd_scheduler #(
    parameter int unsigned GAP_CYCLES   = 1000,
    parameter int unsigned DONE_TIMEOUT = 1_000_000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [3:0]          key_pulse,
    key_cmd_scheduler_if.master cmd,
    output logic                busy,
    output logic [3:0]          pending,
    output logic [7:0]          drop_cnt,
    output logic                timeout_err
);
    localparam int unsigned CNT_W = 20;
    localparam bit               GAP_EN   = (GAP_CYCLES != 0);
    localparam bit               TO_EN    = (DONE_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_EN ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_EN ? DONE_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;

    state_t           state;
    logic [1:0]       last_id;
    logic [CNT_W-1:0] cnt;

    logic             hs_c;
    logic [3:0]       clr_c;
    logic [3:0]       drop_bits_c;
    logic [2:0]       drop_add_c;
    logic [8:0]       drop_sum_c;
    logic [7:0]       drop_next_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [1:0]       winner_c;

    // Handshake, pending clear mask and saturating drop accounting
    always_comb begin
        hs_c        = (state == S_REQ) & cmd.cmd_valid & cmd.cmd_ready;
        clr_c       = hs_c ? (4'b0001 << cmd.cmd_id) : 4'b0000;
        drop_bits_c = key_pulse & pending & ~clr_c;
        drop_add_c  = 3'(drop_bits_c[0]) + 3'(drop_bits_c[1])
                    + 3'(drop_bits_c[2]) + 3'(drop_bits_c[3]);
        drop_sum_c  = 9'(drop_cnt) + 9'(drop_add_c);
        drop_next_c = (drop_sum_c > 9'd255) ? 8'd255 : drop_sum_c[7:0];
        cnt_inc_c   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    end

    // Round-robin pick: first pending bit after last_id, wrapping
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found    = 1'b0;
        idx      = 2'd0;
        winner_c = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_id + 2'(k);
            if (!found && pending[idx]) begin
                winner_c = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            last_id       <= 2'd3;
            cnt           <= '0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_id    <= 2'd0;
            busy          <= 1'b0;
            pending       <= 4'b0000;
            drop_cnt      <= 8'd0;
            timeout_err   <= 1'b0;
        end else begin
            pending     <= (pending & ~clr_c) | key_pulse;
            drop_cnt    <= drop_next_c;
            timeout_err <= 1'b0;
            cnt         <= cnt_inc_c;
            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        cmd.cmd_id    <= winner_c;
                        cmd.cmd_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (hs_c) begin
                        cmd.cmd_valid <= 1'b0;
                        last_id       <= cmd.cmd_id;
                        cnt           <= '0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A tx_done in the final timeout cycle takes priority over the error
                    if (cmd.tx_done || (TO_EN && cnt == TO_LAST)) begin
                        timeout_err <= ~cmd.tx_done;
                        cnt         <= '0;
                        if (GAP_EN) begin
                            state <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: table-driven grant-order vectors with a grant scoreboard,
// plus hand sequences for drops, long stalls, timeout, mid-operation reset and zero gap.
module tb_key_cmd_scheduler;
    localparam int GAP = 4;
    localparam int TO  = 8;

    logic       clk;
    logic       rstn;
    logic [3:0] key_pulse;
    logic       busy;
    logic [3:0] pending;
    logic [7:0] drop_cnt;
    logic       timeout_err;

    logic [3:0] key0;
    logic       busy0;
    logic [3:0] pending0;
    logic [7:0] drop_cnt0;
    logic       timeout_err0;

    key_cmd_scheduler_if bus ();
    key_cmd_scheduler_if bus0 ();

    key_cmd_scheduler #(.GAP_CYCLES(GAP), .DONE_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .key_pulse(key_pulse), .cmd(bus),
        .busy(busy), .pending(pending), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
    );

    key_cmd_scheduler #(.GAP_CYCLES(0), .DONE_TIMEOUT(0)) dut0 (
        .clk(clk), .rstn(rstn), .key_pulse(key0), .cmd(bus0),
        .busy(busy0), .pending(pending0), .drop_cnt(drop_cnt0), .timeout_err(timeout_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] keys;
        int         n;
        logic [1:0] ord [4];
        int         dly;
    } vec_t;

    vec_t       vecs [7];
    logic [1:0] sb [$];
    int         checks = 0;
    int         errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
        chk({tag, "_cmd_id"}, 32'(bus.cmd_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // Wait for an offered command, compare it with the scoreboard, accept it
    task automatic handshake(input logic [3:0] keys);
        int n;
        logic [1:0] e;
        n = 0;
        while (!bus.cmd_valid && n < 200) begin
            step();
            n++;
        end
        chk("grant_valid", 32'(bus.cmd_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: got id %0d with empty scoreboard", bus.cmd_id);
        end else begin
            e = sb.pop_front();
            chk("grant_id", 32'(bus.cmd_id), 32'(e));
        end
        bus.cmd_ready = 1'b1;
        key_pulse     = keys;
        step();
        bus.cmd_ready = 1'b0;
        key_pulse     = 4'b0000;
        chk("valid_low_after_hs", 32'(bus.cmd_valid), 32'd0);
    endtask

    // From the cycle after the handshake: tx_done at offset dly (0 = never), run to IDLE
    task automatic finish_cmd(input int dly, input int exp_idle, input bit exp_to);
        int k;
        int to_cnt;
        int to_at;
        k      = 1;
        to_cnt = 0;
        to_at  = 0;
        while (busy && k < 200) begin
            if (k == dly) bus.tx_done = 1'b1;
            step();
            bus.tx_done = 1'b0;
            k++;
            if (timeout_err) begin
                to_cnt++;
                to_at = k;
            end
        end
        chk("idle_offset", 32'(k), 32'(exp_idle));
        chk("timeout_pulses", 32'(to_cnt), exp_to ? 32'd1 : 32'd0);
        if (exp_to) chk("timeout_offset", 32'(to_at), 32'(TO + 1));
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        int bad;
        int seen;
        rstn          = 1'b0;
        key_pulse     = 4'b0000;
        key0          = 4'b0000;
        bus.cmd_ready = 1'b0;
        bus.tx_done   = 1'b0;
        bus0.cmd_ready = 1'b0;
        bus0.tx_done   = 1'b0;

        vecs[0] = '{keys: 4'b1111, n: 4, ord: '{2'd0, 2'd1, 2'd2, 2'd3}, dly: 1};
        vecs[1] = '{keys: 4'b0001, n: 1, ord: '{2'd0, 2'd0, 2'd0, 2'd0}, dly: 2};
        vecs[2] = '{keys: 4'b1001, n: 2, ord: '{2'd3, 2'd0, 2'd0, 2'd0}, dly: 5};
        vecs[3] = '{keys: 4'b0110, n: 2, ord: '{2'd1, 2'd2, 2'd0, 2'd0}, dly: 3};
        vecs[4] = '{keys: 4'b0101, n: 2, ord: '{2'd0, 2'd2, 2'd0, 2'd0}, dly: 4};
        vecs[5] = '{keys: 4'b1010, n: 2, ord: '{2'd3, 2'd1, 2'd0, 2'd0}, dly: 6};
        vecs[6] = '{keys: 4'b1111, n: 4, ord: '{2'd2, 2'd3, 2'd0, 2'd1}, dly: 7};

        repeat (3) step();
        check_reset_vals("in_reset");
        rstn = 1'b1;
        step();
        check_reset_vals("after_reset");

        // Single press on key 2 with full latency checks
        key_pulse = 4'b0100;
        step();
        key_pulse = 4'b0000;
        chk("single_pending", 32'(pending), 32'b0100);
        chk("single_valid_early", 32'(bus.cmd_valid), 32'd0);
        step();
        chk("single_valid", 32'(bus.cmd_valid), 32'd1);
        chk("single_id", 32'(bus.cmd_id), 32'd2);
        chk("single_busy", 32'(busy), 32'd1);
        sb.push_back(2'd2);
        handshake(4'b0000);
        chk("single_pending_clr", 32'(pending), 32'd0);
        finish_cmd(5, 5 + GAP + 1, 1'b0);
        chk("single_drop", 32'(drop_cnt), 32'd0);

        // Round-robin order table from a fresh pointer
        apply_reset();
        foreach (vecs[v]) begin
            chk("vec_idle", 32'(busy), 32'd0);
            key_pulse = vecs[v].keys;
            step();
            key_pulse = 4'b0000;
            chk("vec_pending", 32'(pending), 32'(vecs[v].keys));
            for (int j = 0; j < vecs[v].n; j++) sb.push_back(vecs[v].ord[j]);
            for (int j = 0; j < vecs[v].n; j++) begin
                handshake(4'b0000);
                finish_cmd(vecs[v].dly, vecs[v].dly + GAP + 1, 1'b0);
            end
        end

        // Drops: repeat press while requesting, press coinciding with the handshake
        key_pulse = 4'b0010;
        step();
        key_pulse = 4'b0000;
        step();
        chk("drop_req_valid", 32'(bus.cmd_valid), 32'd1);
        chk("drop_req_id", 32'(bus.cmd_id), 32'd1);
        key_pulse = 4'b0010;
        step();
        key_pulse = 4'b0000;
        chk("drop_one", 32'(drop_cnt), 32'd1);
        sb.push_back(2'd1);
        handshake(4'b0010);
        chk("hs_press_pending", 32'(pending), 32'b0010);
        chk("hs_press_nodrop", 32'(drop_cnt), 32'd1);
        finish_cmd(3, 3 + GAP + 1, 1'b0);

        key_pulse = 4'b1111;
        step();
        key_pulse = 4'b0000;
        chk("multi_drop_a", 32'(drop_cnt), 32'd2);
        chk("multi_pending", 32'(pending), 32'b1111);
        chk("stall_id_start", 32'(bus.cmd_id), 32'd1);
        key_pulse = 4'b1111;
        step();
        key_pulse = 4'b0000;
        chk("multi_drop_b", 32'(drop_cnt), 32'd6);

        // Long stall with presses: valid and id must hold, drop count saturates
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            key_pulse = (i % 2 == 1) ? 4'b1000 : 4'b0010;
            step();
            if (!bus.cmd_valid || bus.cmd_id != 2'd1 || !busy) bad++;
            if (i == 247) chk("drop_254", 32'(drop_cnt), 32'd254);
        end
        key_pulse = 4'b0000;
        chk("stall_stable", 32'(bad), 32'd0);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Drain: timeout, tx_done on the last wait cycle, then normal completions
        sb.push_back(2'd1);
        sb.push_back(2'd2);
        sb.push_back(2'd3);
        sb.push_back(2'd0);
        handshake(4'b0000);
        finish_cmd(0, TO + GAP + 1, 1'b1);
        handshake(4'b0000);
        finish_cmd(TO, TO + GAP + 1, 1'b0);
        handshake(4'b0000);
        finish_cmd(1, 1 + GAP + 1, 1'b0);
        handshake(4'b0000);
        finish_cmd(2, 2 + GAP + 1, 1'b0);
        chk("drain_pending", 32'(pending), 32'd0);
        chk("drain_drop_held", 32'(drop_cnt), 32'd255);

        // Reset during WAIT with two keys pending
        key_pulse = 4'b1010;
        step();
        key_pulse = 4'b0000;
        sb.push_back(2'd1);
        handshake(4'b0000);
        key_pulse = 4'b0010;
        step();
        key_pulse = 4'b0000;
        chk("rst_pre_pending", 32'(pending), 32'b1010);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_async_pending", 32'(pending), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        step();
        rstn = 1'b1;
        step();
        check_reset_vals("mid_reset");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.cmd_valid || busy) seen++;
        end
        chk("rst_no_cmd", 32'(seen), 32'd0);
        key_pulse = 4'b0110;
        step();
        key_pulse = 4'b0000;
        sb.push_back(2'd1);
        sb.push_back(2'd2);
        handshake(4'b0000);
        finish_cmd(1, 1 + GAP + 1, 1'b0);
        handshake(4'b0000);
        finish_cmd(1, 1 + GAP + 1, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Zero gap, no timeout instance
        key0 = 4'b0011;
        step();
        key0 = 4'b0000;
        step();
        chk("z_valid", 32'(bus0.cmd_valid), 32'd1);
        chk("z_id", 32'(bus0.cmd_id), 32'd0);
        bus0.cmd_ready = 1'b1;
        step();
        bus0.cmd_ready = 1'b0;
        chk("z_valid_low", 32'(bus0.cmd_valid), 32'd0);
        chk("z_pending", 32'(pending0), 32'b0010);
        bad = 0;
        for (int k = 1; k < 20; k++) begin
            if (!busy0 || timeout_err0) bad++;
            step();
        end
        chk("z_long_wait", 32'(bad), 32'd0);
        bus0.tx_done = 1'b1;
        step();
        bus0.tx_done = 1'b0;
        chk("z_idle_busy", 32'(busy0), 32'd0);
        chk("z_idle_valid", 32'(bus0.cmd_valid), 32'd0);
        step();
        chk("z_next_valid", 32'(bus0.cmd_valid), 32'd1);
        chk("z_next_id", 32'(bus0.cmd_id), 32'd1);
        chk("z_drop", 32'(drop_cnt0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_cmd_scheduler.md
# key_cmd_scheduler

Round-robin scheduler that turns debounced one-cycle key-press pulses (4 keys) into a serialized command stream for the Ethernet packet transmitter. Each press is latched as a pending request. Requests are granted one at a time over a valid/ready handshake. The block then waits for the transmitter's completion and enforces a minimum inter-command gap. It sits between the key debouncer outputs and the Ethernet TX control logic.

## Interface
Parameters:
- GAP_CYCLES, 1000: minimum idle cycles after a command completes before the next grant; 0 disables the gap; max 2^20-1.
- DONE_TIMEOUT, 1_000_000: max cycles to wait for tx_done before aborting; 0 disables the timeout; max 2^20-1.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset: asynchronous, active-low.
- key_pulse  in  4  debounced press pulses, active-high, one cycle each; bit i = key i.
- cmd_valid  out  1  command offered to TX.
- cmd_ready  in  1  TX accepts command.
- cmd_id  out  2  key index of offered command.
- tx_done  in  1  one-cycle completion pulse from TX.
- busy  out  1  high whenever state != IDLE.
- pending  out  4  latched unserved requests.
- drop_cnt  out  8  saturating count of presses lost because already pending.
- timeout_err  out  1  one-cycle pulse on DONE_TIMEOUT expiry.

## Operation
- Reset values: cmd_valid=0, cmd_id=0, busy=0, pending=0, drop_cnt=0, timeout_err=0, state=IDLE, rr pointer last_id=3 (key 0 wins first). Reset mid-operation aborts immediately; any command in flight is forgotten.
- Pending latch, per bit i:
  - set on key_pulse[i];
  - cleared on the handshake (cmd_valid & cmd_ready) when cmd_id==i.
  - Set and clear in the same cycle: bit stays 1 (new press queued), no drop.
  - key_pulse[i] while pending[i]=1 and not being cleared: drop, drop_cnt+1, saturating at 255.
  - Multiple simultaneous drops in one cycle add the count of dropped bits, still saturating.
- Arbitration: search pending starting at (last_id+1) mod 4, ascending, wrapping; first set bit wins. last_id updates to cmd_id on the handshake only.
- FSM:
  - IDLE: pending!=0 → load cmd_id = winner, assert cmd_valid, go REQ.
  - REQ: hold cmd_valid=1 and cmd_id stable until cmd_ready. On handshake: cmd_valid=0, clear the pending bit, update last_id, reset wait counter, go WAIT. New presses do not change cmd_id in REQ.
  - WAIT:
    - tx_done → GAP, or IDLE if GAP_CYCLES=0.
    - Else, if DONE_TIMEOUT!=0 and the wait counter reaches DONE_TIMEOUT-1 → pulse timeout_err, go GAP/IDLE as above.
    - tx_done in that same final cycle wins: no error.
  - GAP: counter from 0; at GAP_CYCLES-1 go IDLE.
- tx_done outside WAIT is ignored. cmd_ready outside REQ is ignored.
- Counters are 20-bit unsigned and never wrap; each is cleared on state entry.

## Timing
- key_pulse at cycle t, IDLE, nothing pending: pending[i]=1 at t+1, cmd_valid=1 with cmd_id=i at t+2, busy=1 at t+2.
- Handshake at cycle h: cmd_valid=0 and pending bit cleared at h+1; WAIT occupies cycles from h+1.
- tx_done at cycle d: GAP occupies d+1 … d+GAP_CYCLES; IDLE at d+GAP_CYCLES+1; next cmd_valid no earlier than d+GAP_CYCLES+2. With GAP_CYCLES=0: IDLE at d+1, next cmd_valid at d+2.
- Timeout: no tx_done by cycle h+DONE_TIMEOUT → timeout_err=1 in cycle h+DONE_TIMEOUT+1, next state GAP.
- cmd_valid never deasserts without a handshake except by reset.

## Test plan
- Single press key 2 at cycle 10, cmd_ready tied 1, tx_done 5 cycles after handshake, GAP_CYCLES=4 → cmd_valid/cmd_id=2 at cycle 12, pending=0 at 13, busy low 4 cycles after tx_done+1, drop_cnt=0.
- key_pulse=4'b1111 in one cycle, each command completed → grant order 0,1,2,3. Then press keys 0 and 3 together with last_id=0 → key 3 granted before key 0.
- Press key 1 twice while pending[1]=1 and in REQ with cmd_ready=0 → drop_cnt=1 (second press dropped). Press coinciding with the handshake of key 1 → pending[1] stays 1, no drop. 300 drops → drop_cnt=255.
- cmd_ready held 0 for 50 cycles, pulses on keys 2/3 meanwhile → cmd_id stays constant, cmd_valid stays 1 throughout.
- DONE_TIMEOUT=8, tx_done never sent → timeout_err single pulse 8 cycles after WAIT entry, FSM proceeds to the next pending key. Repeat with tx_done on the 8th WAIT cycle → no error.
- rstn low for 1 cycle during WAIT with pending=4'b1010 → all outputs at reset values next cycle, no command issued until new key_pulse.
